bp_clint_ctrl: RTL and testbench

//  Core-local interruptor (CLINT) controller on the I/O side of the memory-mapped device space.

---
 rtl/bp_clint_ctrl_if.sv | 26 ++
 rtl/bp_clint_ctrl.sv | 140 ++++++++++++++
 tb/tb_bp_clint_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_clint_ctrl_if.sv
// Command/response bus between the I/O crossbar and the CLINT controller.
// Signal suffixes are seen from the CLINT side (slave modport).
interface bp_clint_ctrl_if #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 64
);
    logic                    cmd_v_i;
    logic                    cmd_ready_o;
    logic                    cmd_we_i;
    logic [addr_width_p-1:0] cmd_addr_i;
    logic [data_width_p-1:0] cmd_data_i;
    logic                    resp_v_o;
    logic                    resp_ready_i;
    logic [data_width_p-1:0] resp_data_o;
    logic                    resp_err_o;

    modport slave (
        input  cmd_v_i, cmd_we_i, cmd_addr_i, cmd_data_i, resp_ready_i,
        output cmd_ready_o, resp_v_o, resp_data_o, resp_err_o
    );

    modport master (
        output cmd_v_i, cmd_we_i, cmd_addr_i, cmd_data_i, resp_ready_i,
        input  cmd_ready_o, resp_v_o, resp_data_o, resp_err_o
    );
endinterface

// File: rtl/bp_clint_ctrl.sv
// CLINT controller: mtime counter, per-core mipi/mtimecmp, single-outstanding load/store port.
// Optional mtime prescaler enabled by defining BP_CLINT_PRESCALE_EN.
module bp_clint_ctrl #(
    parameter int num_cores_p      = 1,
    parameter int addr_width_p     = 32,
    parameter int data_width_p     = 64,
    parameter int mtime_prescale_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    bp_clint_ctrl_if.slave         bus,
    output logic [num_cores_p-1:0] soft_irq_o,
    output logic [num_cores_p-1:0] timer_irq_o
);
    localparam int IDX_W = (num_cores_p > 1) ? $clog2(num_cores_p) : 1;
    localparam logic [addr_width_p-1:0] MIPI_BASE  = addr_width_p'(32'h0200_0000);
    localparam logic [addr_width_p-1:0] CMP_BASE   = addr_width_p'(32'h0200_4000);
    localparam logic [addr_width_p-1:0] MTIME_ADDR = addr_width_p'(32'h0200_bff8);

    if (mtime_prescale_p < 2) begin : g_prescale_chk
        $error("mtime_prescale_p must be >= 2");
    end

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t                  r_state, w_state_nxt;
    logic                    w_cmd_ready, w_resp_v;
    logic [data_width_p-1:0] r_mtime;
    logic [data_width_p-1:0] r_mtimecmp [num_cores_p];
    logic [num_cores_p-1:0]  r_mipi;
    logic [num_cores_p-1:0]  r_timer_irq;
    logic [data_width_p-1:0] r_resp_data;
    logic                    r_resp_err;

    logic [addr_width_p-1:0] w_addr;
    logic [10:0]             w_core;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_aligned, w_core_ok;
    logic                    w_hit_mipi, w_hit_cmp, w_hit_mtime, w_err;
    logic                    w_hs, w_mtime_wr, w_tick;
    logic [data_width_p-1:0] w_rdata;

    // Windows are 16 KiB aligned, so bits above 13 select the window and 13:3 the core.
    assign w_addr      = bus.cmd_addr_i;
    assign w_core      = w_addr[13:3];
    assign w_idx       = w_core[IDX_W-1:0];
    assign w_aligned   = (w_addr[2:0] == 3'b000);
    assign w_core_ok   = (w_core < 11'(num_cores_p));
    assign w_hit_mipi  = (w_addr[addr_width_p-1:14] == MIPI_BASE[addr_width_p-1:14]) && w_aligned && w_core_ok;
    assign w_hit_cmp   = (w_addr[addr_width_p-1:14] == CMP_BASE[addr_width_p-1:14]) && w_aligned && w_core_ok;
    assign w_hit_mtime = (w_addr == MTIME_ADDR);
    assign w_err       = !(w_hit_mipi || w_hit_cmp || w_hit_mtime);
    assign w_hs        = bus.cmd_v_i && (r_state == S_IDLE);
    assign w_mtime_wr  = w_hs && bus.cmd_we_i && w_hit_mtime;

    always_comb begin
        w_rdata = '0;
        if (w_hit_mipi)       w_rdata = {{(data_width_p-1){1'b0}}, r_mipi[w_idx]};
        else if (w_hit_cmp)   w_rdata = r_mtimecmp[w_idx];
        else if (w_hit_mtime) w_rdata = r_mtime;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_resp_v    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_v_i) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_resp_v = 1'b1;
                if (bus.resp_ready_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else if (w_hs) begin
            r_resp_data <= (w_err || bus.cmd_we_i) ? '0 : w_rdata;
            r_resp_err  <= w_err;
        end
    end

`ifdef BP_CLINT_PRESCALE_EN
    localparam int PS_W = $clog2(mtime_prescale_p);
    logic [PS_W-1:0] r_presc;

    assign w_tick = (r_presc == PS_W'(mtime_prescale_p - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i || w_mtime_wr) r_presc <= '0;
        else if (w_tick)           r_presc <= '0;
        else                       r_presc <= r_presc + 1'b1;
    end
`else
    assign w_tick = 1'b1;
`endif

    // A store in the same cycle as a tick takes the written value without the +1.
    always_ff @(posedge clk_i) begin
        if (reset_i)         r_mtime <= '0;
        else if (w_mtime_wr) r_mtime <= bus.cmd_data_i;
        else if (w_tick)     r_mtime <= r_mtime + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_mipi <= '0;
            for (int c = 0; c < num_cores_p; c++) r_mtimecmp[c] <= '1;
        end else if (w_hs && bus.cmd_we_i) begin
            if (w_hit_mipi) r_mipi[w_idx]     <= bus.cmd_data_i[0];
            if (w_hit_cmp)  r_mtimecmp[w_idx] <= bus.cmd_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) r_timer_irq <= '0;
        else begin
            for (int c = 0; c < num_cores_p; c++) r_timer_irq[c] <= (r_mtime >= r_mtimecmp[c]);
        end
    end

    assign bus.cmd_ready_o = w_cmd_ready;
    assign bus.resp_v_o    = w_resp_v;
    assign bus.resp_data_o = r_resp_data;
    assign bus.resp_err_o  = r_resp_err;
    assign soft_irq_o      = r_mipi;
    assign timer_irq_o     = r_timer_irq;
endmodule

// File: tb/tb_bp_clint_ctrl.sv
// Self-checking bench for bp_clint_ctrl (default build, unprescaled mtime, two cores).
module tb_bp_clint_ctrl;
    localparam int NC = 2;
    localparam logic [31:0] MIPI_A  = 32'h0200_0000;
    localparam logic [31:0] CMP_A   = 32'h0200_4000;
    localparam logic [31:0] MTIME_A = 32'h0200_bff8;
    localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
    } exp_t;

    logic          clk_i   = 1'b0;
    logic          reset_i = 1'b1;
    logic [NC-1:0] soft_irq_o;
    logic [NC-1:0] timer_irq_o;

    exp_t          sb_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [63:0]   m_mtime;
    logic [NC-1:0] irq_at_resp;
    logic [NC-1:0] soft_at_resp;

    always #5 clk_i = ~clk_i;

    bp_clint_ctrl_if #(.addr_width_p(32), .data_width_p(64)) bus();

    bp_clint_ctrl #(
        .num_cores_p(NC), .addr_width_p(32), .data_width_p(64), .mtime_prescale_p(8)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .bus        (bus),
        .soft_irq_o (soft_irq_o),
        .timer_irq_o(timer_irq_o)
    );

    // Reference mtime: counts every cycle, reloads on a bench-driven mtime store.
    always @(posedge clk_i) begin
        if (reset_i) m_mtime <= 64'd0;
        else if (bus.cmd_v_i && bus.cmd_we_i && bus.cmd_addr_i == MTIME_A) m_mtime <= bus.cmd_data_i;
        else m_mtime <= m_mtime + 64'd1;
    end

    task automatic do_cmd(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                          input logic [63:0] exp_data, input logic exp_err, input string nm);
        exp_t e;
        logic got;
        int   lat;
        n_tests++;
        if (bus.cmd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s cmd_ready: got %b want 1", nm, bus.cmd_ready_o);
        end
        e.data = exp_data;
        e.err  = exp_err;
        sb_q.push_back(e);
        bus.cmd_v_i    = 1'b1;
        bus.cmd_we_i   = we;
        bus.cmd_addr_i = addr;
        bus.cmd_data_i = wdata;
        @(posedge clk_i);
        @(negedge clk_i);
        bus.cmd_v_i = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.resp_v_o === 1'b1) begin
                got = 1'b1;
                lat = i;
                break;
            end
            @(negedge clk_i);
        end
        e = sb_q.pop_front();
        n_tests++;
        if (!got || lat != 0) begin
            n_fail++;
            $display("FAIL %s resp_latency: got %0d extra cycles (seen=%b) want 0", nm, lat, got);
        end
        if (got) begin
            irq_at_resp  = timer_irq_o;
            soft_at_resp = soft_irq_o;
            n_tests++;
            if (bus.resp_data_o !== e.data) begin
                n_fail++;
                $display("FAIL %s resp_data: got %h want %h", nm, bus.resp_data_o, e.data);
            end
            n_tests++;
            if (bus.resp_err_o !== e.err) begin
                n_fail++;
                $display("FAIL %s resp_err: got %b want %b", nm, bus.resp_err_o, e.err);
            end
            n_tests++;
            if (bus.cmd_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s ready_in_resp: got %b want 0", nm, bus.cmd_ready_o);
            end
            @(posedge clk_i);
            @(negedge clk_i);
            n_tests++;
            if (bus.resp_v_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s resp_v_after_accept: got %b want 0", nm, bus.resp_v_o);
            end
        end
    endtask

    task automatic test_reset();
        bus.cmd_v_i      = 1'b0;
        bus.cmd_we_i     = 1'b0;
        bus.cmd_addr_i   = '0;
        bus.cmd_data_i   = '0;
        bus.resp_ready_i = 1'b1;
        reset_i          = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        n_tests++;
        if (bus.cmd_ready_o !== 1'b1 || bus.resp_v_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_handshake: got ready=%b v=%b want ready=1 v=0", bus.cmd_ready_o, bus.resp_v_o);
        end
        n_tests++;
        if (bus.resp_data_o !== 64'd0 || bus.resp_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_resp: got data=%h err=%b want 0/0", bus.resp_data_o, bus.resp_err_o);
        end
        n_tests++;
        if (soft_irq_o !== '0 || timer_irq_o !== '0) begin
            n_fail++;
            $display("FAIL rst_irq: got soft=%b timer=%b want 00/00", soft_irq_o, timer_irq_o);
        end
        reset_i = 1'b0;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        do_cmd(1'b0, MTIME_A, 64'd0, 64'd5, 1'b0, "mtime_after_5_idle");
        n_tests++;
        if (soft_irq_o !== '0 || timer_irq_o !== '0) begin
            n_fail++;
            $display("FAIL idle_irq: got soft=%b timer=%b want 00/00", soft_irq_o, timer_irq_o);
        end
    endtask

    task automatic test_mipi();
        do_cmd(1'b1, MIPI_A, ONES, 64'd0, 1'b0, "mipi0_store");
        n_tests++;
        if (soft_at_resp !== 2'b01 || soft_irq_o !== 2'b01) begin
            n_fail++;
            $display("FAIL mipi0_soft_irq: got %b/%b want 01/01", soft_at_resp, soft_irq_o);
        end
        do_cmd(1'b0, MIPI_A, 64'd0, 64'h1, 1'b0, "mipi0_load");
        do_cmd(1'b1, MIPI_A + 32'd8, 64'h2, 64'd0, 1'b0, "mipi1_store_bit1");
        n_tests++;
        if (soft_irq_o !== 2'b01) begin
            n_fail++;
            $display("FAIL mipi1_bit0_only: got %b want 01", soft_irq_o);
        end
        do_cmd(1'b1, MIPI_A + 32'd8, 64'h3, 64'd0, 1'b0, "mipi1_store_set");
        do_cmd(1'b0, MIPI_A + 32'd8, 64'd0, 64'h1, 1'b0, "mipi1_load");
        n_tests++;
        if (soft_irq_o !== 2'b11) begin
            n_fail++;
            $display("FAIL mipi_both: got %b want 11", soft_irq_o);
        end
        do_cmd(1'b1, MIPI_A, 64'd0, 64'd0, 1'b0, "mipi0_clear");
        do_cmd(1'b1, MIPI_A + 32'd8, 64'd0, 64'd0, 1'b0, "mipi1_clear");
        n_tests++;
        if (soft_irq_o !== 2'b00) begin
            n_fail++;
            $display("FAIL mipi_cleared: got %b want 00", soft_irq_o);
        end
    endtask

    task automatic test_timer();
        logic [63:0] cmp;
        logic        rise;
        cmp = m_mtime + 64'd10;
        do_cmd(1'b1, CMP_A, cmp, 64'd0, 1'b0, "cmp0_store");
        n_tests++;
        if (irq_at_resp !== 2'b00) begin
            n_fail++;
            $display("FAIL timer_early: got %b want 00", irq_at_resp);
        end
        rise = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (timer_irq_o[0] === 1'b1) begin
                rise = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        n_tests++;
        if (!rise || m_mtime != cmp + 64'd1) begin
            n_fail++;
            $display("FAIL timer_rise: got rise=%b at mtime %h want rise at mtime %h", rise, m_mtime, cmp + 64'd1);
        end
        n_tests++;
        if (timer_irq_o[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL timer1_quiet: got %b want 0", timer_irq_o[1]);
        end
        do_cmd(1'b0, CMP_A, 64'd0, cmp, 1'b0, "cmp0_load");
        do_cmd(1'b1, CMP_A, m_mtime + 64'd1000, 64'd0, 1'b0, "cmp0_raise");
        n_tests++;
        if (irq_at_resp[0] !== 1'b1 || timer_irq_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL timer_deassert: got +1=%b +2=%b want 1 then 0", irq_at_resp[0], timer_irq_o[0]);
        end
    endtask

    task automatic test_wrap();
        do_cmd(1'b1, CMP_A, ONES, 64'd0, 1'b0, "cmp0_ones");
        do_cmd(1'b1, MTIME_A, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0, "mtime_store_max");
        n_tests++;
        if (timer_irq_o !== 2'b00) begin
            n_fail++;
            $display("FAIL wrap_pre: got %b want 00", timer_irq_o);
        end
        @(negedge clk_i);
        n_tests++;
        if (timer_irq_o !== 2'b11) begin
            n_fail++;
            $display("FAIL wrap_at_max: got %b want 11", timer_irq_o);
        end
        @(negedge clk_i);
        n_tests++;
        if (timer_irq_o !== 2'b00) begin
            n_fail++;
            $display("FAIL wrap_after_zero: got %b want 00", timer_irq_o);
        end
        do_cmd(1'b0, MTIME_A, 64'd0, 64'd1, 1'b0, "mtime_post_wrap");
    endtask

    task automatic test_errors();
        do_cmd(1'b0, MIPI_A + 32'd4, 64'd0, 64'd0, 1'b1, "ld_misaligned");
        do_cmd(1'b0, MIPI_A + 32'(8 * NC), 64'd0, 64'd0, 1'b1, "ld_core_oob");
        do_cmd(1'b1, MIPI_A + 32'd4, 64'd1, 64'd0, 1'b1, "st_mipi_misaligned");
        do_cmd(1'b1, MIPI_A + 32'(8 * NC), 64'd1, 64'd0, 1'b1, "st_mipi_oob");
        n_tests++;
        if (soft_irq_o !== 2'b00) begin
            n_fail++;
            $display("FAIL err_no_mipi_change: got %b want 00", soft_irq_o);
        end
        do_cmd(1'b1, CMP_A + 32'd4, 64'd0, 64'd0, 1'b1, "st_cmp_misaligned");
        do_cmd(1'b1, CMP_A + 32'(8 * NC), 64'd0, 64'd0, 1'b1, "st_cmp_oob");
        do_cmd(1'b0, CMP_A, 64'd0, ONES, 1'b0, "cmp0_unchanged");
        do_cmd(1'b0, CMP_A + 32'd8, 64'd0, ONES, 1'b0, "cmp1_unchanged");
        do_cmd(1'b1, 32'h0200_bffc, 64'd0, 64'd0, 1'b1, "st_mtime_misaligned");
        do_cmd(1'b0, 32'h0200_bff0, 64'd0, 64'd0, 1'b1, "ld_near_mtime");
        do_cmd(1'b0, 32'h0300_0000, 64'd0, 64'd0, 1'b1, "ld_unmapped");
        do_cmd(1'b0, MTIME_A, 64'd0, m_mtime, 1'b0, "mtime_unchanged");
    endtask

    task automatic test_back_to_back();
        logic [63:0] base;
        base = m_mtime;
        for (int k = 0; k < 4; k++) begin
            do_cmd(1'b0, MTIME_A, 64'd0, base + 64'(2 * k), 1'b0, "b2b_mtime");
        end
    endtask

    task automatic test_reset_mid_resp();
        bus.resp_ready_i = 1'b0;
        bus.cmd_v_i      = 1'b1;
        bus.cmd_we_i     = 1'b0;
        bus.cmd_addr_i   = CMP_A + 32'd8;
        bus.cmd_data_i   = 64'd0;
        @(posedge clk_i);
        @(negedge clk_i);
        bus.cmd_v_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (bus.resp_v_o !== 1'b1 || bus.resp_data_o !== ONES) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%b data=%h want v=1 data=%h", i, bus.resp_v_o, bus.resp_data_o, ONES);
            end
            @(negedge clk_i);
        end
        reset_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        n_tests++;
        if (bus.resp_v_o !== 1'b0 || bus.resp_data_o !== 64'd0 || bus.cmd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midresp_reset: got v=%b data=%h ready=%b want 0/0/1", bus.resp_v_o, bus.resp_data_o, bus.cmd_ready_o);
        end
        reset_i          = 1'b0;
        bus.resp_ready_i = 1'b1;
        do_cmd(1'b0, MTIME_A, 64'd0, 64'd0, 1'b0, "mtime_after_midreset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mipi();
        test_timer();
        test_wrap();
        test_errors();
        test_back_to_back();
        test_reset_mid_resp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
